pipe_result_drain: RTL and testbench

- Consumer end of the datapath stage-register chain. Accepts the final stage's x/valid/overflow/cnt/error bundle and buffers accepted results in a small FIFO.
- Presents buffered results to a downstream reader over a valid/ready handshake.
- Generates the stage-enable for the upstream register chain, which provides backpressure. It also keeps sticky status and a result tally.

---
 rtl/pipe_result_drain.sv | 103 ++++++++++
 tb/tb_pipe_result_drain.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_result_drain.sv
// Consumer end of the stage-register chain: buffers accepted results in a
// small first-word-fall-through FIFO, drives the upstream stage enable and keeps sticky status.
module pipe_result_drain #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned TALLY_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_x,
  input  logic                  in_valid,
  input  logic                  in_overflow,
  input  logic [CNT_W-1:0]      in_cnt,
  input  logic                  in_error,
  output logic                  pipe_en,
  output logic [DATA_W-1:0]     out_x,
  output logic                  out_overflow,
  output logic [CNT_W-1:0]      out_cnt,
  output logic                  out_error,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clr_status,
  output logic                  err_sticky,
  output logic                  ovf_sticky,
  output logic [TALLY_W-1:0]    tally,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic              ovf;
    logic [CNT_W-1:0]  cnt;
    logic              err;
  } entry_t;

  entry_t                mem [DEPTH];
  entry_t                head;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  push;
  logic                  pop;

  // Enable depends only on registered occupancy, so out_ready never reaches upstream combinationally.
  assign pipe_en   = (level_q != LEVEL_FULL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & pipe_en;
  assign pop       = out_valid & out_ready;
  assign level     = level_q;

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{x: in_x, ovf: in_overflow, cnt: in_cnt, err: in_error};
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_x        = head.x;
  assign out_overflow = head.ovf;
  assign out_cnt      = head.cnt;
  assign out_error    = head.err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // A push coinciding with a clear lands on top of the cleared state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
      ovf_sticky <= 1'b0;
      tally      <= '0;
    end else if (clr_status) begin
      err_sticky <= push & in_error;
      ovf_sticky <= push & in_overflow;
      tally      <= push ? TALLY_W'(1) : '0;
    end else if (push) begin
      err_sticky <= err_sticky | in_error;
      ovf_sticky <= ovf_sticky | in_overflow;
      if (tally != '1) tally <= tally + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_result_drain.sv
// Self-checking bench for pipe_result_drain: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_pipe_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_x;
  logic        in_valid;
  logic        in_overflow;
  logic [2:0]  in_cnt;
  logic        in_error;
  logic        pipe_en;
  logic [15:0] out_x;
  logic        out_overflow;
  logic [2:0]  out_cnt;
  logic        out_error;
  logic        out_valid;
  logic        out_ready;
  logic        clr_status;
  logic        err_sticky;
  logic        ovf_sticky;
  logic [7:0]  tally;
  logic [2:0]  level;

  pipe_result_drain #(
    .DATA_W(16), .CNT_W(3), .DEPTH_LOG2(2), .TALLY_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_x(in_x), .in_valid(in_valid), .in_overflow(in_overflow),
    .in_cnt(in_cnt), .in_error(in_error),
    .pipe_en(pipe_en),
    .out_x(out_x), .out_overflow(out_overflow), .out_cnt(out_cnt),
    .out_error(out_error), .out_valid(out_valid), .out_ready(out_ready),
    .clr_status(clr_status), .err_sticky(err_sticky), .ovf_sticky(ovf_sticky),
    .tally(tally), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] x;
    logic        ovf;
    logic [2:0]  cnt;
    logic        err;
  } ent_t;

  // Reference model: a queue of accepted results plus plain status variables.
  ent_t q[$];
  bit   m_err;
  bit   m_ovf;
  int   m_tally;
  int   max_level_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_err = 0; m_ovf = 0; m_tally = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"},     32'(level),      32'(q.size()));
    chk({tag, ".pipe_en"},   32'(pipe_en),    32'(q.size() != 4));
    chk({tag, ".out_valid"}, 32'(out_valid),  32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".out_x"},   32'(out_x),        32'(q[0].x));
      chk({tag, ".out_cnt"}, 32'(out_cnt),      32'(q[0].cnt));
      chk({tag, ".out_ovf"}, 32'(out_overflow), 32'(q[0].ovf));
      chk({tag, ".out_err"}, 32'(out_error),    32'(q[0].err));
    end
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_err));
    chk({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(m_ovf));
    chk({tag, ".tally"},      32'(tally),      32'(m_tally));
  endtask

  // Called at posedge+1: drive inputs, clock once, advance model, compare.
  task automatic cycle(input string tag, input bit v, input logic [15:0] x, input bit ovf,
                       input logic [2:0] cnt, input bit err, input bit rdy, input bit clr);
    bit   do_push;
    bit   do_pop;
    ent_t e;
    in_valid = v; in_x = x; in_overflow = ovf; in_cnt = cnt; in_error = err;
    out_ready = rdy; clr_status = clr;
    do_push = v && (q.size() < 4);
    do_pop  = rdy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (clr) begin m_err = 0; m_ovf = 0; m_tally = 0; end
    if (do_push) begin
      e.x = x; e.ovf = ovf; e.cnt = cnt; e.err = err;
      q.push_back(e);
      m_err = m_err | err;
      m_ovf = m_ovf | ovf;
      if (m_tally < 255) m_tally++;
    end
    if (q.size() > max_level_seen) max_level_seen = q.size();
    check_model(tag);
  endtask

  typedef struct {
    bit          v;
    logic [15:0] x;
    logic [2:0]  cnt;
    bit          rdy;
    logic [2:0]  e_level;
    bit          e_pe;
    bit          e_ov;
    logic [15:0] e_x;
    logic [7:0]  e_tally;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(bit v, logic [15:0] x, logic [2:0] cnt, bit rdy,
                              logic [2:0] lv, bit pe, bit ov, logic [15:0] ex, logic [7:0] t);
    vec_t r;
    r.v = v; r.x = x; r.cnt = cnt; r.rdy = rdy;
    r.e_level = lv; r.e_pe = pe; r.e_ov = ov; r.e_x = ex; r.e_tally = t;
    return r;
  endfunction

  initial begin
    // Single pass, then fill to full with backpressure and drain in order.
    tbl[0]  = mk(1, 16'h1234, 3'd5, 1, 3'd1, 1, 1, 16'h1234, 8'd1);
    tbl[1]  = mk(0, 16'h0000, 3'd0, 1, 3'd0, 1, 0, 16'h0000, 8'd1);
    tbl[2]  = mk(1, 16'h0001, 3'd1, 0, 3'd1, 1, 1, 16'h0001, 8'd2);
    tbl[3]  = mk(1, 16'h0002, 3'd2, 0, 3'd2, 1, 1, 16'h0001, 8'd3);
    tbl[4]  = mk(1, 16'h0003, 3'd3, 0, 3'd3, 1, 1, 16'h0001, 8'd4);
    tbl[5]  = mk(1, 16'h0004, 3'd4, 0, 3'd4, 0, 1, 16'h0001, 8'd5);
    tbl[6]  = mk(1, 16'h0005, 3'd5, 0, 3'd4, 0, 1, 16'h0001, 8'd5);
    tbl[7]  = mk(1, 16'h0005, 3'd5, 1, 3'd3, 1, 1, 16'h0002, 8'd5);
    tbl[8]  = mk(1, 16'h0005, 3'd5, 0, 3'd4, 0, 1, 16'h0002, 8'd6);
    tbl[9]  = mk(0, 16'h0000, 3'd0, 1, 3'd3, 1, 1, 16'h0003, 8'd6);
    tbl[10] = mk(0, 16'h0000, 3'd0, 1, 3'd2, 1, 1, 16'h0004, 8'd6);
    tbl[11] = mk(0, 16'h0000, 3'd0, 1, 3'd1, 1, 1, 16'h0005, 8'd6);
    tbl[12] = mk(0, 16'h0000, 3'd0, 1, 3'd0, 1, 0, 16'h0000, 8'd6);

    rst = 1'b0; in_x = '0; in_valid = 0; in_overflow = 0; in_cnt = '0; in_error = 0;
    out_ready = 0; clr_status = 0;
    model_reset();
    max_level_seen = 0;
    #3;
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.out_x",     32'(out_x),     0);
    chk("reset.out_cnt",   32'(out_cnt),   0);
    chk("reset.level",     32'(level),     0);
    chk("reset.pipe_en",   32'(pipe_en),   1);
    chk("reset.tally",     32'(tally),     0);
    chk("reset.sticky",    32'({err_sticky, ovf_sticky}), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int unsigned i = 0; i < 13; i++) begin
      cycle($sformatf("tbl%0d", i), tbl[i].v, tbl[i].x, 0, tbl[i].cnt, 0, tbl[i].rdy, 0);
      chk($sformatf("tbl%0d.level", i),   32'(level),   32'(tbl[i].e_level));
      chk($sformatf("tbl%0d.pipe_en", i), 32'(pipe_en), 32'(tbl[i].e_pe));
      chk($sformatf("tbl%0d.valid", i),   32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d.out_x", i), 32'(out_x), 32'(tbl[i].e_x));
      chk($sformatf("tbl%0d.tally", i),   32'(tally),   32'(tbl[i].e_tally));
    end

    // Streaming with simultaneous push/pop; pointers wrap three times.
    cycle("clr", 0, 0, 0, 0, 0, 1, 1);
    max_level_seen = 0;
    for (int unsigned i = 0; i < 12; i++) cycle("stream", 1, 16'(i), 0, 3'(i), 0, 1, 0);
    cycle("stream.drain", 0, 0, 0, 0, 0, 1, 0);
    chk("stream.tally", 32'(tally), 12);
    chk("stream.maxlevel", 32'(max_level_seen), 1);

    // Sticky flags and clear-with-push.
    cycle("st.clr", 0, 0, 0, 0, 0, 1, 1);
    cycle("st.r1", 1, 16'h11, 0, 0, 0, 1, 0);
    cycle("st.r2", 1, 16'h12, 0, 0, 1, 1, 0);
    cycle("st.r3", 1, 16'h13, 1, 0, 0, 1, 0);
    chk("st.err", 32'(err_sticky), 1);
    chk("st.ovf", 32'(ovf_sticky), 1);
    cycle("st.clrpush", 1, 16'h14, 1, 0, 0, 1, 1);
    chk("st.clr.err",   32'(err_sticky), 0);
    chk("st.clr.ovf",   32'(ovf_sticky), 1);
    chk("st.clr.tally", 32'(tally), 1);
    cycle("st.drain", 0, 0, 0, 0, 0, 1, 0);

    // Tally saturation.
    for (int unsigned i = 0; i < 260; i++) cycle("sat", 1, 16'(i), 0, 0, 0, 1, 0);
    chk("sat.tally", 32'(tally), 255);
    cycle("sat.drain", 0, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset with three entries buffered.
    for (int unsigned i = 0; i < 3; i++) cycle("ar.fill", 1, 16'(16'hA0 + i), 1, 0, 1, 0, 0);
    chk("ar.level_pre", 32'(level), 3);
    in_valid = 0;
    #2 rst = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid), 0);
    chk("ar.level",     32'(level),     0);
    chk("ar.tally",     32'(tally),     0);
    chk("ar.sticky",    32'({err_sticky, ovf_sticky}), 0);
    chk("ar.pipe_en",   32'(pipe_en),   1);
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    cycle("ar.beef", 1, 16'hBEEF, 0, 3'd2, 0, 0, 0);
    chk("ar.head", 32'(out_x), 32'h0000BEEF);
    cycle("ar.drain", 0, 0, 0, 0, 0, 1, 0);

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 400; i++) begin
      cycle("rnd", bit'($urandom_range(0, 1)), 16'($urandom), bit'($urandom_range(0, 1)),
            3'($urandom), bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
